// File: rtl/misr_ora.sv
// LFSR-based multiple-input signature register used as an output response analyzer.
// Optional per-bit response masking is enabled by defining MISR_XMASK_EN.
module misr_ora #(
    parameter int WIDTH         = 4,
    parameter int PATTERN_COUNT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             resp_valid,
    input  logic [1:WIDTH]   resp,
    input  logic [1:WIDTH]   golden,
`ifdef MISR_XMASK_EN
    input  logic [1:WIDTH]   mask,
`endif
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [1:WIDTH]   signature
);

    localparam int CNT_W = $clog2(PATTERN_COUNT + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PATTERN_COUNT - 1);
    localparam logic [1:WIDTH] SEED = WIDTH'(1);

    // Tap positions shared with the pattern generator, packed as up to four byte-wide indices.
    function automatic logic [31:0] tap_list(input int w);
        case (w)
            3:       tap_list = {8'd3,  8'd2,  8'd0,  8'd0};
            4:       tap_list = {8'd4,  8'd3,  8'd0,  8'd0};
            5:       tap_list = {8'd5,  8'd3,  8'd0,  8'd0};
            6:       tap_list = {8'd6,  8'd5,  8'd0,  8'd0};
            7:       tap_list = {8'd7,  8'd6,  8'd0,  8'd0};
            8:       tap_list = {8'd8,  8'd6,  8'd5,  8'd4};
            9:       tap_list = {8'd9,  8'd5,  8'd0,  8'd0};
            10:      tap_list = {8'd10, 8'd7,  8'd0,  8'd0};
            11:      tap_list = {8'd11, 8'd9,  8'd0,  8'd0};
            12:      tap_list = {8'd12, 8'd6,  8'd4,  8'd1};
            13:      tap_list = {8'd13, 8'd4,  8'd3,  8'd1};
            14:      tap_list = {8'd14, 8'd5,  8'd3,  8'd1};
            15:      tap_list = {8'd15, 8'd14, 8'd0,  8'd0};
            16:      tap_list = {8'd16, 8'd15, 8'd13, 8'd4};
            17:      tap_list = {8'd17, 8'd14, 8'd0,  8'd0};
            18:      tap_list = {8'd18, 8'd11, 8'd0,  8'd0};
            19:      tap_list = {8'd19, 8'd6,  8'd2,  8'd1};
            20:      tap_list = {8'd20, 8'd17, 8'd0,  8'd0};
            21:      tap_list = {8'd21, 8'd19, 8'd0,  8'd0};
            22:      tap_list = {8'd22, 8'd21, 8'd0,  8'd0};
            23:      tap_list = {8'd23, 8'd18, 8'd0,  8'd0};
            24:      tap_list = {8'd24, 8'd23, 8'd22, 8'd17};
            25:      tap_list = {8'd25, 8'd22, 8'd0,  8'd0};
            26:      tap_list = {8'd26, 8'd6,  8'd2,  8'd1};
            27:      tap_list = {8'd27, 8'd5,  8'd2,  8'd1};
            28:      tap_list = {8'd28, 8'd25, 8'd0,  8'd0};
            29:      tap_list = {8'd29, 8'd27, 8'd0,  8'd0};
            30:      tap_list = {8'd30, 8'd6,  8'd4,  8'd1};
            default: tap_list = 32'd0;
        endcase
    endfunction

    function automatic logic [1:WIDTH] tap_vec(input int w);
        logic [31:0] list;
        int          pos;
        tap_vec = '0;
        list    = tap_list(w);
        for (int j = 0; j < 4; j++) begin
            pos = int'(list[j*8 +: 8]);
            if (pos != 0) tap_vec = tap_vec | (SEED << (WIDTH - pos));
        end
    endfunction

    localparam logic [1:WIDTH] TAPS = tap_vec(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, CMP, DONE} state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] count;
    logic [1:WIDTH]   data;
    logic [1:WIDTH]   next_sig;
    logic             fb;
    logic             launch;
    logic             accept;

`ifdef MISR_XMASK_EN
    assign data = resp & ~mask;
`else
    assign data = resp;
`endif

    // XNOR feedback: all-ones would lock the bare LFSR, but the response XOR keeps it moving.
    assign fb       = ~^(signature & TAPS);
    assign next_sig = {fb, signature[1:WIDTH-1]} ^ data;

    assign launch = start && (state == IDLE || state == DONE);
    assign accept = resp_valid && (state == RUN);
    assign busy   = (state == RUN) || (state == CMP);
    assign done   = (state == DONE);

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: the default assignment up front keeps this block free of inferred latches.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (resp_valid && count == LAST_IDX) next_state = CMP;
            CMP:     next_state = DONE;
            DONE:    if (start) next_state = RUN;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            signature <= SEED;
            count     <= '0;
            pass      <= 1'b0;
        end else if (launch) begin
            signature <= SEED;
            count     <= '0;
            pass      <= 1'b0;
        end else if (accept) begin
            signature <= next_sig;
            count     <= count + 1'b1;
        end else if (state == CMP) begin
            pass <= (signature == golden);
        end
    end

endmodule

// File: tb/tb_misr_ora.sv
// Randomized scoreboard bench for misr_ora at WIDTH=4 across three PATTERN_COUNT values.
// Define MISR_XMASK_EN on both bench and RTL to cover the masking build.
module tb_misr_ora;

    localparam int W = 4;
    localparam int NI = 3;
    localparam int PCS [NI] = '{1, 2, 15};
    localparam logic [1:W] SEED = 4'b0001;

    typedef struct {
        int        inst;
        logic [1:W] sig;
        logic      pass;
        int        cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_s      [NI];
    logic       resp_valid_s [NI];
    logic [1:W] resp_s       [NI];
    logic [1:W] golden_s     [NI];
`ifdef MISR_XMASK_EN
    logic [1:W] mask_s       [NI];
`endif
    logic       busy_s       [NI];
    logic       done_s       [NI];
    logic       pass_s       [NI];
    logic [1:W] sig_s        [NI];

    exp_t       sb [$];
    logic [1:W] rq [$];
    logic [1:W] mq [$];
    logic       done_q [NI];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        misr_ora #(.WIDTH(W), .PATTERN_COUNT(PCS[g])) u_dut (
            .clk        (clk),
            .reset      (reset),
            .start      (start_s[g]),
            .resp_valid (resp_valid_s[g]),
            .resp       (resp_s[g]),
            .golden     (golden_s[g]),
`ifdef MISR_XMASK_EN
            .mask       (mask_s[g]),
`endif
            .busy       (busy_s[g]),
            .done       (done_s[g]),
            .pass       (pass_s[g]),
            .signature  (sig_s[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the register is a right shift of the integer image with the
    // XNOR of taps 4 and 3 (integer bits 0 and 1) entering at the top, then XORed with the data.
    function automatic logic [1:W] model_step(input logic [1:W] s, input logic [1:W] d);
        int v;
        int fb;
        v  = int'(s);
        fb = 1 ^ ($countones(v & 3) & 1);
        v  = (v >> 1) | (fb << (W - 1));
        v  = v ^ int'(d);
        return v[W-1:0];
    endfunction

    // Monitor: every rising done is matched against the oldest expected result.
    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (done_s[g] && !done_q[g]) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: instance %0d raised done with nothing expected", g);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_instance", g, e.inst);
                    check("sb_signature", 32'(sig_s[g]), 32'(e.sig));
                    check("sb_pass", 32'(pass_s[g]), 32'(e.pass));
                    check("sb_done_latency", cyc, e.cyc);
                end
            end
            done_q[g] = done_s[g];
        end
    end

    task automatic check_reset_state(input int g);
        check($sformatf("rst_sig_%0d", g),  32'(sig_s[g]),  32'(SEED));
        check($sformatf("rst_busy_%0d", g), 32'(busy_s[g]), 0);
        check($sformatf("rst_done_%0d", g), 32'(done_s[g]), 0);
        check($sformatf("rst_pass_%0d", g), 32'(pass_s[g]), 0);
    endtask

    // One complete run on instance g using responses in rq and masks in mq.
    task automatic do_run(input int g, input int gap_at, input bit rand_gaps,
                          input logic [1:W] golden_val, input bit golden_from_model,
                          input bit hold_start);
        logic [1:W] sig_m;
        logic [1:W] m_eff;
        logic       pass_exp;
        int         n;
        int         ngap;
        int         t;
        n     = rq.size();
        sig_m = SEED;
        @(posedge clk); #1;
        start_s[g]      = 1'b1;
        resp_valid_s[g] = 1'b0;
        @(posedge clk); #1;
        check("start_sig_seed", 32'(sig_s[g]), 32'(SEED));
        check("start_busy", 32'(busy_s[g]), 1);
        check("start_done_clr", 32'(done_s[g]), 0);
        check("start_pass_clr", 32'(pass_s[g]), 0);
        start_s[g] = hold_start;
        for (int k = 0; k < n; k++) begin
            ngap = rand_gaps ? int'($urandom_range(0, 2)) : (k == gap_at ? 1 : 0);
            repeat (ngap) begin
                resp_valid_s[g] = 1'b0;
                resp_s[g]       = W'($urandom);
                @(posedge clk); #1;
                check("gap_hold", 32'(sig_s[g]), 32'(sig_m));
            end
`ifdef MISR_XMASK_EN
            mask_s[g] = mq[k];
            m_eff     = mq[k];
`else
            m_eff = '0;
`endif
            resp_valid_s[g] = 1'b1;
            resp_s[g]       = rq[k];
            sig_m           = model_step(sig_m, rq[k] & ~m_eff);
            if (k == n - 1) begin
                golden_s[g] = golden_from_model ? sig_m : golden_val;
                pass_exp    = (golden_s[g] == sig_m);
                sb.push_back('{inst: g, sig: sig_m, pass: pass_exp, cyc: cyc + 2});
            end
            @(posedge clk); #1;
            check("step_sig", 32'(sig_s[g]), 32'(sig_m));
        end
        resp_valid_s[g] = 1'b0;
        check("cmp_busy", 32'(busy_s[g]), 1);
        check("cmp_not_done", 32'(done_s[g]), 0);
        @(posedge clk); #1;
        start_s[g] = 1'b0;
        t = 0;
        while (!done_s[g] && t < 8) begin
            @(posedge clk); #1;
            t++;
        end
        check("done_reached", 32'(done_s[g]), 1);
        repeat (2) begin
            resp_valid_s[g] = 1'b1;
            resp_s[g]       = W'($urandom);
            golden_s[g]     = W'($urandom);
            @(posedge clk); #1;
            check("done_hold_sig", 32'(sig_s[g]), 32'(sig_m));
            check("done_hold_pass", 32'(pass_s[g]), 32'(pass_exp));
            check("done_hold_done", 32'(done_s[g]), 1);
        end
        resp_valid_s[g] = 1'b0;
    endtask

    task automatic fill_random(input int n, input bit with_mask);
        rq.delete();
        mq.delete();
        for (int k = 0; k < n; k++) begin
            rq.push_back(W'($urandom));
            mq.push_back(with_mask ? W'($urandom) : '0);
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int g = 0; g < NI; g++) begin
            start_s[g]      = 1'b0;
            resp_valid_s[g] = 1'b0;
            resp_s[g]       = '0;
            golden_s[g]     = '0;
            done_q[g]       = 1'b0;
`ifdef MISR_XMASK_EN
            mask_s[g]       = '0;
`endif
        end
        #2;
        for (int g = 0; g < NI; g++) check_reset_state(g);
        #20 reset = 1'b0;

        // Responses in IDLE must not be compacted.
        @(posedge clk); #1;
        resp_valid_s[0] = 1'b1;
        resp_s[0]       = 4'b1111;
        repeat (2) begin
            @(posedge clk); #1;
            check("idle_ignore_sig", 32'(sig_s[0]), 32'(SEED));
            check("idle_busy", 32'(busy_s[0]), 0);
        end
        resp_valid_s[0] = 1'b0;

        rq = '{4'b0000}; mq = '{4'b0000};
        do_run(0, -1, 1'b0, 4'b0000, 1'b0, 1'b0);
        rq = '{4'b1111}; mq = '{4'b0000};
        do_run(0, -1, 1'b0, 4'b0000, 1'b0, 1'b0);
        rq = '{4'b0000, 4'b0000}; mq = '{4'b0000, 4'b0000};
        do_run(1, 1, 1'b0, 4'b1000, 1'b0, 1'b0);

        // start held through RUN/CMP, then a restart from a passing DONE.
        fill_random(2, 1'b0);
        do_run(1, -1, 1'b1, 4'b0000, 1'b1, 1'b1);
        fill_random(2, 1'b0);
        do_run(1, -1, 1'b1, W'($urandom), 1'b0, 1'b0);

        repeat (6) begin
            fill_random(PCS[2], 1'b0);
            do_run(2, -1, 1'b1, W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

`ifdef MISR_XMASK_EN
        rq = '{4'b1111}; mq = '{4'b1111};
        do_run(0, -1, 1'b0, 4'b0000, 1'b0, 1'b0);
        repeat (3) begin
            fill_random(PCS[2], 1'b1);
            do_run(2, -1, 1'b1, W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end
`endif

        // Asynchronous reset in the middle of a run.
        rq = '{4'b0000}; mq = '{4'b0000};
        do_run(0, -1, 1'b0, 4'b0000, 1'b0, 1'b0);
        @(posedge clk); #1;
        start_s[2] = 1'b1;
        @(posedge clk); #1;
        start_s[2]      = 1'b0;
        resp_valid_s[2] = 1'b1;
        repeat (3) begin
            resp_s[2] = W'($urandom);
            @(posedge clk); #1;
        end
        #2 reset = 1'b1;
        #1;
        check_reset_state(2);
        check_reset_state(0);
        resp_valid_s[2] = 1'b0;
        #3 reset = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            check("post_reset_idle", 32'(busy_s[2]), 0);
        end
        fill_random(PCS[2], 1'b0);
        do_run(2, -1, 1'b1, W'($urandom), 1'b1, 1'b0);

        repeat (2) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
